multicycle_controlpath: RTL
===========================

# multicycle_controlpath

Multi-cycle successor to the single-cycle control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath control strobes per state. It waits on a memory ready handshake with a bounded timeout, latches the decoded opcode, and counts retired instructions. It sits between the instruction register / memory interface and the register file / ALU datapath.

## Interface
- ALUFN_W, 3: ALUFn width, ≥3; codes are zero-extended.
- TIMEOUT_W, 4: memory wait counter width; MAX_WAIT = 2**TIMEOUT_W − 1.
- CNT_W, 16: retired-instruction counter width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE, or resume from HALT.
- OpFn  in  5  instruction opcode/function field from the IR; sampled in DECODE.
- mem_ready  in  1  memory completion for the current FETCH/MEM access.
- PCWrite, IRWrite, RegWrite, RegDst, ALUSrc, MemRead, MemWrite, MemToReg, NIA  out  1 each  datapath strobes.
- ALUFn  out  ALUFN_W  ALU operation.
- halted  out  1  high in HALT.
- trap  out  1  high in TRAP.
- state_o  out  3  state code.
- retired  out  CNT_W  count of retired instructions.

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- Outputs are decoded from the registered state and latched op_q. An output not listed for a state is 0. NIA=1 in every state except HALT.
- Opcode class = op_q[4:2]:
  - 000 R-type: ALUFn={0,op_q[1:0]}, RegDst=1, MemToReg=1.
  - 001 imm: ALUFn=100, ALUSrc=1, MemToReg=1.
  - 010 load: ALUFn=101, ALUSrc=1, MemToReg=0.
  - 011 store: ALUFn=110, ALUSrc=1.
  - 100 compare/branch: ALUFn=111, no register write.
  - 101 halt.
  - 110/111 illegal.
- IDLE: start → FETCH.
- FETCH: MemRead=1. IRWrite=1 in the cycle mem_ready=1, then → DECODE.
- DECODE: op_q<=OpFn.
  - class 101 → HALT.
  - illegal → TRAP.
  - otherwise → EXEC.
- EXEC: ALUFn/ALUSrc per class.
  - R/imm → WB.
  - load/store → MEM.
  - class 100: PCWrite=1 → FETCH.
- MEM:
  - load: MemRead=1; on mem_ready → WB.
  - store: MemWrite=1; on mem_ready, PCWrite=1 → FETCH.
- WB: RegWrite=1, RegDst/MemToReg per class, PCWrite=1 → FETCH.
- HALT: NIA=0, halted=1. start → FETCH; otherwise hold.
- TRAP: trap=1. Held until rst_n asserts.
- wait_cnt clears on entering FETCH or MEM and increments each FETCH/MEM cycle with mem_ready=0. If mem_ready=0 and wait_cnt==MAX_WAIT → TRAP. mem_ready=1 in that same cycle wins (normal transition).
- retired increments by 1 on every cycle with PCWrite=1 and wraps modulo 2**CNT_W.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, op_q=0, wait_cnt=0, retired=0.
  - All strobes 0 except NIA=1; ALUFn=0, halted=0, trap=0, state_o=0.
- Zero-wait latency from entering FETCH to re-entering FETCH:
  - R/imm: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - class 100: 3 cycles.
- Each not-ready memory cycle adds 1 cycle.
- The trap is taken after 2**TIMEOUT_W consecutive not-ready cycles in one FETCH or MEM visit.
- start is ignored outside IDLE/HALT.
- OpFn is sampled only in the DECODE cycle; changes at other times have no effect.
- Reset mid-instruction aborts immediately. No strobe may remain asserted after rst_n falls.

## Test plan
- Reset, start, R-type OpFn=00010, mem_ready=1 constant → states 1,2,3,5,1; ALUFn=010 in EXEC; RegWrite=1, RegDst=1, PCWrite=1 in WB; retired=1.
- Load OpFn=01000, mem_ready low 3 cycles in MEM → MEM held 4 cycles with MemRead=1, then WB with MemToReg=0, RegWrite=1; total 8 cycles FETCH→FETCH.
- Store OpFn=01100 then compare OpFn=10000 → MemWrite=1 only in MEM and never RegWrite; PCWrite in MEM, then in EXEC; retired=2.
- Halt OpFn=10100 → HALT, NIA=0, halted=1 held 10 cycles; start=1 → FETCH, NIA=1.
- TIMEOUT_W=2, mem_ready=0 in FETCH → TRAP after exactly 4 not-ready cycles, trap=1 held. Separately, mem_ready=1 on the 4th cycle → DECODE, no trap. Illegal OpFn=11000 → TRAP from DECODE.
- CNT_W=2, 5 branch instructions → retired wraps 3→0→1. rst_n pulsed low mid-MEM → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/multicycle_controlpath.sv
//------------------------------------------------------------------------------
// multicycle_controlpath
//
// Multi-cycle instruction sequencer. Each instruction passes through the
// FETCH/DECODE/EXEC/MEM/WB states. The datapath strobes are decoded from the
// registered state and the opcode latched in DECODE. A bounded wait on
// mem_ready guards FETCH and MEM. Retired instructions are counted.
//
// Parameters
//   ALUFN_W   : ALUFn width (>= 3); ALU codes are zero-extended
//   TIMEOUT_W : memory wait counter width; MAX_WAIT = 2**TIMEOUT_W - 1
//   CNT_W     : retired-instruction counter width
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : leave IDLE, or resume from HALT
//   OpFn      : opcode/function field from the IR, sampled in DECODE
//   mem_ready : completion of the current FETCH/MEM memory access
//   PCWrite, IRWrite, RegWrite, RegDst, ALUSrc,
//   MemRead, MemWrite, MemToReg, NIA : datapath strobes
//   ALUFn     : ALU operation
//   halted    : high in HALT
//   trap      : high in TRAP
//   state_o   : current state code
//   retired   : retired instruction count, wraps
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module multicycle_controlpath #(
    parameter int unsigned ALUFN_W   = 3,
    parameter int unsigned TIMEOUT_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4:0]         OpFn,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               NIA,
    output logic [ALUFN_W-1:0] ALUFn,
    output logic               halted,
    output logic               trap,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [TIMEOUT_W-1:0] MAX_WAIT = '1;

    state_t               state;
    logic [4:0]           op_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [2:0]           cls;
    logic [2:0]           alu_code;
    logic                 timeout;

    assign cls = op_q[4:2];

    // Ready in the final allowed cycle still completes the access normally.
    assign timeout = !mem_ready && (wait_cnt == MAX_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            if (PCWrite)
                retired <= retired + CNT_W'(1);

            // Every FETCH/MEM exit goes through a ready (or trap) cycle, so
            // clearing whenever the access is not stalled also clears it on
            // each fresh entry to FETCH or MEM.
            if ((state == S_FETCH || state == S_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            else
                wait_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready)
                        state <= S_DECODE;
                    else if (timeout)
                        state <= S_TRAP;
                end
                S_DECODE: begin
                    op_q <= OpFn;
                    case (OpFn[4:2])
                        3'b000, 3'b001, 3'b010, 3'b011, 3'b100: state <= S_EXEC;
                        3'b101:                                 state <= S_HALT;
                        default:                                state <= S_TRAP;
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        3'b000, 3'b001: state <= S_WB;
                        3'b010, 3'b011: state <= S_MEM;
                        default:        state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        state <= (cls == 3'b010) ? S_WB : S_FETCH;
                    else if (timeout)
                        state <= S_TRAP;
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (start)
                        state <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are a pure decode of the registered state so that an
    // asynchronous reset drops them in the same cycle.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        NIA      = 1'b1;
        halted   = 1'b0;
        trap     = 1'b0;
        alu_code = 3'b000;
        state_o  = state;

        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
            end
            S_EXEC: begin
                case (cls)
                    3'b000: alu_code = {1'b0, op_q[1:0]};
                    3'b001: begin alu_code = 3'b100; ALUSrc = 1'b1; end
                    3'b010: begin alu_code = 3'b101; ALUSrc = 1'b1; end
                    3'b011: begin alu_code = 3'b110; ALUSrc = 1'b1; end
                    3'b100: begin alu_code = 3'b111; PCWrite = 1'b1; end
                    default: alu_code = 3'b000;
                endcase
            end
            S_MEM: begin
                if (cls == 3'b011) begin
                    MemWrite = 1'b1;
                    PCWrite  = mem_ready;
                end else begin
                    MemRead = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                RegDst   = (cls == 3'b000);
                MemToReg = (cls == 3'b000) || (cls == 3'b001);
            end
            S_HALT: begin
                NIA    = 1'b0;
                halted = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                NIA = 1'b1;
            end
        endcase

        ALUFn = (state == S_EXEC) ? ALUFN_W'(alu_code) : '0;
    end

endmodule
